// File: rtl/seg7_byte_decoder.sv
// Recovers hex nibbles from active-low 7-segment codes and pairs them into bytes
// (first digit = high nibble) on a valid/ready output, with error and timeout tracking.
module seg7_byte_decoder #(
  parameter int TIMEOUT = 1000,
  parameter int ERR_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       seg_code,
  input  logic             seg_valid,
  output logic             seg_ready,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             code_err,
  output logic             timeout_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HAVE_HI = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  // Returns {legal, nibble}; anything outside the display encoder's table is illegal.
  function automatic logic [4:0] seg_decode(input logic [6:0] code);
    logic [4:0] res;
    case (code)
      7'h40:   res = {1'b1, 4'h0};
      7'h79:   res = {1'b1, 4'h1};
      7'h24:   res = {1'b1, 4'h2};
      7'h30:   res = {1'b1, 4'h3};
      7'h19:   res = {1'b1, 4'h4};
      7'h12:   res = {1'b1, 4'h5};
      7'h02:   res = {1'b1, 4'h6};
      7'h78:   res = {1'b1, 4'h7};
      7'h00:   res = {1'b1, 4'h8};
      7'h10:   res = {1'b1, 4'h9};
      7'h08:   res = {1'b1, 4'hA};
      7'h03:   res = {1'b1, 4'hB};
      7'h46:   res = {1'b1, 4'hC};
      7'h21:   res = {1'b1, 4'hD};
      7'h06:   res = {1'b1, 4'hE};
      7'h0E:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  state_t           r_state;
  logic [15:0]      r_timer;
  logic             r_seg_ready;
  logic [7:0]       r_byte_out;
  logic             r_byte_valid;
  logic             r_code_err;
  logic             r_timeout_err;
  logic [ERR_W-1:0] r_err_count;

  logic [4:0] w_dec;
  logic       w_legal;
  logic [3:0] w_nib;
  logic       w_accept;
  logic       w_code_err;
  logic       w_tmo;

  assign w_dec      = seg_decode(seg_code);
  assign w_legal    = w_dec[4];
  assign w_nib      = w_dec[3:0];
  assign w_accept   = seg_valid && r_seg_ready;
  assign w_code_err = w_accept && !w_legal;
  // An accepted code on the deadline cycle takes priority over the timeout.
  assign w_tmo      = (r_state == ST_HAVE_HI) && !w_accept && (r_timer == TMO_LAST);

  // Main state machine with registered handshake, data and error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_EMPTY;
      r_timer       <= 16'd0;
      r_seg_ready   <= 1'b1;
      r_byte_out    <= 8'h00;
      r_byte_valid  <= 1'b0;
      r_code_err    <= 1'b0;
      r_timeout_err <= 1'b0;
      r_err_count   <= {ERR_W{1'b0}};
    end else begin
      r_code_err    <= w_code_err;
      r_timeout_err <= w_tmo;
      if ((w_code_err || w_tmo) && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + ERR_W'(1);
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_accept && w_legal) begin
            r_byte_out[7:4] <= w_nib;
            r_timer         <= 16'd0;
            r_state         <= ST_HAVE_HI;
          end
        end
        ST_HAVE_HI: begin
          r_timer <= r_timer + 16'd1;
          if (w_accept) begin
            if (w_legal) begin
              r_byte_out[3:0] <= w_nib;
              r_byte_valid    <= 1'b1;
              r_seg_ready     <= 1'b0;
              r_state         <= ST_FULL;
            end else begin
              r_state <= ST_EMPTY;
            end
          end else if (w_tmo) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (byte_ready) begin
            r_byte_valid <= 1'b0;
            r_seg_ready  <= 1'b1;
            r_state      <= ST_EMPTY;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_seg_ready  <= 1'b1;
          r_byte_valid <= 1'b0;
        end
      endcase
    end
  end

  assign seg_ready   = r_seg_ready;
  assign byte_out    = r_byte_out;
  assign byte_valid  = r_byte_valid;
  assign code_err    = r_code_err;
  assign timeout_err = r_timeout_err;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// Directed bench for seg7_byte_decoder (TIMEOUT=4, ERR_W=2): table sweep of all
// legal codes plus hand-written backpressure, timeout, illegal-code and reset sequences.
module tb_seg7_byte_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] seg_code;
  logic       seg_valid;
  logic       seg_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       code_err;
  logic       timeout_err;
  logic [1:0] err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] hi;
    logic [6:0] lo;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  seg7_byte_decoder #(.TIMEOUT(4), .ERR_W(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_code    (seg_code),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .code_err    (code_err),
    .timeout_err (timeout_err),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  // Model of the team's nibble-to-segment display encoder.
  function automatic logic [6:0] enc(input logic [3:0] n);
    logic [6:0] c;
    case (n)
      4'h0: c = 7'h40; 4'h1: c = 7'h79; 4'h2: c = 7'h24; 4'h3: c = 7'h30;
      4'h4: c = 7'h19; 4'h5: c = 7'h12; 4'h6: c = 7'h02; 4'h7: c = 7'h78;
      4'h8: c = 7'h00; 4'h9: c = 7'h10; 4'hA: c = 7'h08; 4'hB: c = 7'h03;
      4'hC: c = 7'h46; 4'hD: c = 7'h21; 4'hE: c = 7'h06; default: c = 7'h0E;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [6:0] code);
    seg_code  = code;
    seg_valid = 1'b1;
    tick();
    seg_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_out"}, 32'(byte_out), 32'h00);
    check({tag, "_byte_valid"}, 32'(byte_valid), 32'd0);
    check({tag, "_code_err"}, 32'(code_err), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_seg_ready"}, 32'(seg_ready), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    check_reset_vals(tag);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] lo_n;
    reset      = 1'b0;
    seg_code   = 7'h7F;
    seg_valid  = 1'b0;
    byte_ready = 1'b1;

    for (int i = 0; i < 16; i++) begin
      lo_n        = 4'(i * 7 + 3);
      vecs[i].hi  = enc(4'(i));
      vecs[i].lo  = enc(lo_n);
      vecs[i].exp = {4'(i), lo_n};
    end

    do_reset("rst0");

    // Basic pair 3,C -> 3C
    send(7'h30);
    check("basic_hi_valid", 32'(byte_valid), 32'd0);
    send(7'h46);
    check("basic_valid", 32'(byte_valid), 32'd1);
    check("basic_byte", 32'(byte_out), 32'h3C);
    check("basic_ready", 32'(seg_ready), 32'd0);
    check("basic_errcnt", 32'(err_count), 32'd0);
    tick();
    check("basic_drop", 32'(byte_valid), 32'd0);
    check("basic_ready2", 32'(seg_ready), 32'd1);

    // Full-table sweep, back to back at one byte per 3 cycles
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].hi);
      check($sformatf("sweep%0d_mid", i), 32'(byte_valid), 32'd0);
      send(vecs[i].lo);
      check($sformatf("sweep%0d_valid", i), 32'(byte_valid), 32'd1);
      check($sformatf("sweep%0d_byte", i), 32'(byte_out), 32'(vecs[i].exp));
      tick();
      check($sformatf("sweep%0d_xfer", i), 32'(byte_valid), 32'd0);
    end

    // Illegal code in EMPTY
    send(7'h7F);
    check("ill_empty_pulse", 32'(code_err), 32'd1);
    check("ill_empty_cnt", 32'(err_count), 32'd1);
    check("ill_empty_ready", 32'(seg_ready), 32'd1);
    tick();
    check("ill_empty_pulse_end", 32'(code_err), 32'd0);
    send(7'h79);
    check("ill_empty_then_hi", 32'(byte_valid), 32'd0);
    send(7'h24);
    check("ill_empty_then_byte", 32'(byte_out), 32'h12);
    tick();

    // Backpressure holding A5
    do_reset("rst1");
    byte_ready = 1'b0;
    send(7'h08);
    send(7'h12);
    check("bp_valid", 32'(byte_valid), 32'd1);
    check("bp_byte", 32'(byte_out), 32'hA5);
    seg_code  = 7'h79;
    seg_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp%0d_ready", k), 32'(seg_ready), 32'd0);
      check($sformatf("bp%0d_byte", k), 32'(byte_out), 32'hA5);
      check($sformatf("bp%0d_valid", k), 32'(byte_valid), 32'd1);
    end
    seg_valid  = 1'b0;
    byte_ready = 1'b1;
    tick();
    check("bp_xfer", 32'(byte_valid), 32'd0);
    tick();
    check("bp_one_only", 32'(byte_valid), 32'd0);
    send(7'h79);
    check("bp_empty_after", 32'(byte_valid), 32'd0);
    send(7'h79);
    check("bp_next_byte", 32'(byte_out), 32'h11);
    tick();

    // Timeout after TIMEOUT idle cycles
    do_reset("rst2");
    send(7'h24);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("tmo_wait%0d", k), 32'(timeout_err), 32'd0);
    end
    tick();
    check("tmo_pulse", 32'(timeout_err), 32'd1);
    check("tmo_cnt", 32'(err_count), 32'd1);
    check("tmo_no_byte", 32'(byte_valid), 32'd0);
    tick();
    check("tmo_pulse_end", 32'(timeout_err), 32'd0);
    send(7'h79);
    check("tmo_empty_hi", 32'(byte_valid), 32'd0);
    send(7'h19);
    check("tmo_next_byte", 32'(byte_out), 32'h14);
    tick();

    // Legal code on the deadline cycle wins
    do_reset("rst3");
    send(7'h24);
    tick();
    tick();
    tick();
    send(7'h40);
    check("race_valid", 32'(byte_valid), 32'd1);
    check("race_byte", 32'(byte_out), 32'h20);
    check("race_no_tmo", 32'(timeout_err), 32'd0);
    check("race_cnt", 32'(err_count), 32'd0);
    tick();

    // Illegal code in HAVE_HI drops the high nibble
    send(7'h12);
    send(7'h55);
    check("ill_hi_pulse", 32'(code_err), 32'd1);
    check("ill_hi_no_byte", 32'(byte_valid), 32'd0);
    check("ill_hi_ready", 32'(seg_ready), 32'd1);
    send(7'h00);
    check("ill_hi_next_mid", 32'(byte_valid), 32'd0);
    send(7'h0E);
    check("ill_hi_next_valid", 32'(byte_valid), 32'd1);
    check("ill_hi_next_byte", 32'(byte_out), 32'h8F);
    tick();

    // Error counter saturation at 3
    do_reset("rst4");
    for (int k = 1; k <= 5; k++) begin
      send(7'h7F);
      check($sformatf("sat%0d", k), 32'(err_count), (k < 3) ? 32'(k) : 32'd3);
    end

    // Reset in HAVE_HI and in FULL
    send(7'h12);
    do_reset("rst_hi");
    byte_ready = 1'b0;
    send(7'h12);
    send(7'h40);
    check("pre_rst_full", 32'(byte_valid), 32'd1);
    do_reset("rst_full");
    tick();
    check("post_rst_idle", 32'(byte_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
